// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit owning HI/LO; define MDU_FAST_MUL_EN for a single-cycle multiplier.
// 33 cycles start-to-result (32 iterations + FIX); stallreq holds off D-stage HI/LO users while busy.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             hiloD,
  input  logic             hiwriteW,
  input  logic             lowriteW,
  input  logic [WIDTH-1:0] wdataW,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stallreq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               is_div_q, is_div_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q;

  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               unused_rem_msb;

  // Signs only matter for MULT/DIV (opE[0] == 0).
  assign sa    = ~opE[0] & srcaE[WIDTH-1];
  assign sb    = ~opE[0] & srcbE[WIDTH-1];
  assign mag_a = sa ? -srcaE : srcaE;
  assign mag_b = sb ? -srcbE : srcbE;

  assign mul_sum = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q})
                            : {1'b0, acc_q[2*WIDTH-1:WIDTH]};

  // Partial remainder is always below the divisor, so the shifted value fits in WIDTH+1 bits.
  assign div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};

  assign prod_fix = neg_lo_q ? -acc_q : acc_q;
  assign quo_fix  = dz_q ? {WIDTH{1'b1}} : (neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign rem_fix  = neg_hi_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  assign unused_rem_msb = rem_q[WIDTH];

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_a, fast_b, fast_prod;
  assign fast_a    = {{WIDTH{sa}}, srcaE};
  assign fast_b    = {{WIDTH{sb}}, srcbE};
  assign fast_prod = fast_a * fast_b;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opnd_d   = opnd_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    hi_d     = hiwriteW ? wdataW : hi_q;
    lo_d     = lowriteW ? wdataW : lo_q;

    case (state_q)
      S_IDLE: begin
        if (startE) begin
          cnt_d = '0;
          rem_d = '0;
          if (opE[1]) begin
            acc_d    = {{WIDTH{1'b0}}, mag_a};
            opnd_d   = mag_b;
            neg_lo_d = sa ^ sb;
            neg_hi_d = sa;
            is_div_d = 1'b1;
            dz_d     = (srcbE == '0);
            state_d  = S_DIV;
          end else begin
`ifdef MDU_FAST_MUL_EN
            hi_d = fast_prod[2*WIDTH-1:WIDTH];
            lo_d = fast_prod[WIDTH-1:0];
`else
            acc_d    = {{WIDTH{1'b0}}, mag_b};
            opnd_d   = mag_a;
            neg_lo_d = sa ^ sb;
            neg_hi_d = sa ^ sb;
            is_div_d = 1'b0;
            dz_d     = 1'b0;
            state_d  = S_MUL;
`endif
          end
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end
      S_DIV: begin
        // Restoring step: keep the trial difference only when it did not borrow.
        if (!div_trial[WIDTH]) begin
          rem_d               = div_trial;
          acc_d[WIDTH-1:0]    = {acc_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d               = div_shift;
          acc_d[WIDTH-1:0]    = {acc_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opnd_q   <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opnd_q   <= opnd_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign stallreq = busy_q & hiloD;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: table of mult/div vectors plus MTLO collision and mid-op reset sequences.
module tb_mdu_iter;
  localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_CYC = 0;
`else
  localparam int MUL_CYC = 33;
`endif
  localparam int DIV_CYC = 33;

  logic         clk = 1'b0;
  logic         reset, startE, hiloD, hiwriteW, lowriteW;
  logic [1:0]   opE;
  logic [W-1:0] srcaE, srcbE, wdataW;
  logic [W-1:0] hi, lo;
  logic         busy, stallreq;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .startE(startE), .opE(opE),
    .srcaE(srcaE), .srcbE(srcbE), .hiloD(hiloD),
    .hiwriteW(hiwriteW), .lowriteW(lowriteW), .wdataW(wdataW),
    .hi(hi), .lo(lo), .busy(busy), .stallreq(stallreq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; the next posedge is the start edge. Returns at the first idle negedge.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int cyc, output int stl);
    startE = 1'b1; opE = op; srcaE = a; srcbE = b;
    @(negedge clk);
    startE = 1'b0; srcaE = 32'hDEAD_BEEF; srcbE = 32'h0BAD_F00D;
    cyc = 0; stl = 0;
    while (busy && cyc < 100) begin
      cyc++;
      stl += int'(stallreq);
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, ehi, elo;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int cyc, stl, ecyc;

    vecs[0]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1]  = '{2'b01, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006};
    vecs[2]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[3]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[4]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[5]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[6]  = '{2'b10, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFF2};
    vecs[7]  = '{2'b10, 32'h1234_5678, 32'h0,         32'h1234_5678, 32'hFFFF_FFFF};
    vecs[8]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[9]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[10] = '{2'b10, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[11] = '{2'b11, 32'hFFFF_FFFF, 32'd10,        32'd5,         32'h1999_9999};
    vecs[12] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};

    reset = 1'b1; startE = 1'b0; opE = 2'b00; srcaE = '0; srcbE = '0;
    hiloD = 1'b0; hiwriteW = 1'b0; lowriteW = 1'b0; wdataW = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_stallreq", {31'b0, stallreq}, 32'h0);

    hiloD = 1'b1;
    @(negedge clk);
    check("idle_stallreq", {31'b0, stallreq}, 32'h0);
    hiloD = 1'b0;
    @(negedge clk);

    // Back-to-back: each vector starts in the first idle cycle after the previous one.
    hiloD = 1'b1;
    for (int i = 0; i < 13; i++) begin
      ecyc = vecs[i].op[1] ? DIV_CYC : MUL_CYC;
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, stl);
      check($sformatf("v%0d_busy_cycles", i), cyc, ecyc);
      check($sformatf("v%0d_stall_cycles", i), stl, ecyc);
      check($sformatf("v%0d_stall_end", i), {31'b0, stallreq}, 32'h0);
      check($sformatf("v%0d_hi", i), hi, vecs[i].ehi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].elo);
    end
    hiloD = 1'b0;

    // MTLO colliding with FIX loses; the same write two cycles later lands.
    startE = 1'b1; opE = 2'b11; srcaE = 32'd100; srcbE = 32'd7;
    @(negedge clk);
    startE = 1'b0;
    for (int k = 0; k < 32; k++) @(negedge clk);
    check("fix_cycle_busy", {31'b0, busy}, 32'h1);
    lowriteW = 1'b1; wdataW = 32'hAAAA_5555;
    @(negedge clk);
    lowriteW = 1'b0;
    check("mtlo_collide_lo", lo, 32'd14);
    check("mtlo_collide_hi", hi, 32'd2);
    check("mtlo_collide_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    lowriteW = 1'b1;
    @(negedge clk);
    lowriteW = 1'b0;
    check("mtlo_late_lo", lo, 32'hAAAA_5555);
    check("mtlo_late_hi", hi, 32'd2);
    hiwriteW = 1'b1; wdataW = 32'h1357_2468;
    @(negedge clk);
    hiwriteW = 1'b0;
    check("mthi_hi", hi, 32'h1357_2468);
    check("mthi_lo", lo, 32'hAAAA_5555);

    // Reset in cycle 10 of a divide discards it; the unit then works normally.
    hiloD = 1'b1;
    startE = 1'b1; opE = 2'b10; srcaE = 32'hFFFF_FF9C; srcbE = 32'd7;
    @(negedge clk);
    startE = 1'b0;
    for (int k = 0; k < 9; k++) @(negedge clk);
    check("midop_busy", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_stallreq", {31'b0, stallreq}, 32'h0);
    @(negedge clk);
    check("midrst_idle_busy", {31'b0, busy}, 32'h0);
    hiloD = 1'b0;
    run_op(2'b01, 32'd2, 32'd3, cyc, stl);
    check("post_rst_cycles", cyc, MUL_CYC);
    check("post_rst_hi", hi, 32'h0);
    check("post_rst_lo", lo, 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit for the 5-stage MIPS pipeline, owning the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU from the E stage and runs them over multiple cycles. While an operation is in flight, it raises a stall request toward the hazard unit whenever the D-stage instruction touches HI/LO. The hazard unit consumes stall requests; this block generates them, so it is the requesting end of that stall interface.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `startE`  in  1  E-stage instruction is a mult/div; sampled only in IDLE.
- `opE`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `srcaE`, `srcbE`  in  WIDTH  operands (rs, rt); srcbE is the divisor.
- `hiloD`  in  1  D-stage instruction is MFHI/MFLO/MTHI/MTLO or a mult/div.
- `hiwriteW`, `lowriteW`  in  1  MTHI/MTLO write enables.
- `wdataW`  in  WIDTH  MTHI/MTLO data.
- `hi`, `lo`  out  WIDTH  architectural HI/LO, registered.
- `busy`  out  1  operation in flight (state != IDLE), registered.
- `stallreq`  out  1  combinational: `busy & hiloD`; ORed into StallD/StallF/FlushE by the hazard unit.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE, with `startE`: latch operand magnitudes. Magnitudes are two's-complement absolutes for signed ops and raw values for unsigned ops. Also latch the result signs (quotient sign = sa^sb; remainder sign = sa), clear the 6-bit count, then go to MUL or DIV.
- MUL: shift-add, one multiplier bit per cycle, 64-bit accumulator. After 32 iterations, go to FIX.
- DIV: restoring division, one quotient bit per cycle. The remainder register is 33 bits so the trial subtract keeps its borrow. After 32 iterations, go to FIX.
- FIX: negate the product/quotient/remainder as required. Write HI/LO:
  - mult: HI = product[63:32], LO = product[31:0].
  - div: LO = quotient, HI = remainder.
  - Then return to IDLE.
- Divide by zero (srcbE == 0): LO = 0xFFFFFFFF, HI = srcaE, unchanged. Cycle count is the same as a normal divide.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO = 0x80000000, HI = 0. This falls out of the magnitude arithmetic and must not be special-cased into an error.
- `startE` when not IDLE: ignored. The hazard unit guarantees this never happens via `stallreq`.
- MTHI/MTLO in the same cycle as FIX: the FIX result wins. MTHI/MTLO in any other cycle: the written register updates on that edge.
- Reset, including mid-operation: state IDLE, count 0, hi = lo = 0, busy = 0. The in-flight result is discarded.

## Timing
- Start edge: the `startE` sample in IDLE. `busy` is 1 from the following cycle.
- MUL: 32 iteration cycles + 1 FIX cycle. HI/LO are valid and `busy` is 0 in the 34th cycle after the start edge.
- DIV: identical count (32 + FIX). Total start-to-result latency is 33 edges.
- `stallreq` has no registered delay. It drops in the same cycle `busy` drops, so an MFHI held in D proceeds on that edge and reads the new value.
- Back-to-back: a new `startE` is accepted in the first IDLE cycle after FIX.
- Reset values: hi = 0, lo = 0, busy = 0, stallreq = 0.

## Configuration
- `MDU_FAST_MUL_EN`:
  - Defined: MULT/MULTU compute with a single-cycle WIDTH×WIDTH multiplier. HI/LO update on the start edge itself; the block never enters MUL/FIX for multiplies, and `busy` stays 0. DIV is unchanged.
  - Undefined: the iterative MUL path above is used. No hardware multiplier is inferred.

## Test plan
- MULT: srcaE = 0xFFFFFFFD (-3), srcbE = 7 -> after 33 edges, HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. `busy` is high for exactly 33 cycles. With `MDU_FAST_MUL_EN`, the same values appear one edge after start and `busy` never rises.
- DIVU: 100 / 7 -> LO = 14, HI = 2. DIV: -100 / 7 -> LO = 0xFFFFFFF2 (-14), HI = 0xFFFFFFFE (-2).
- Divide by zero: DIV 0x12345678 / 0 -> LO = 0xFFFFFFFF, HI = 0x12345678. Overflow: DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- Stall handshake: hold `hiloD` = 1 during the divide -> `stallreq` = 1 every busy cycle and 0 in the cycle HI/LO become valid. Pulse `hiloD` while idle -> `stallreq` stays 0.
- MTLO collisions: `lowriteW` with 0xAAAA5555 in the FIX cycle -> LO = the div result. The same write two cycles later -> LO = 0xAAAA5555.
- Reset at cycle 10 of a DIV -> next cycle hi = lo = 0 and busy = 0. A subsequent MULTU 2×3 completes normally: HI = 0, LO = 6.
